// File: rtl/ro_freq_meter_if.sv
// rtl/ro_freq_meter_if.sv - request/result bundle between a measurement requester and ro_freq_meter
interface ro_freq_meter_if #(
    parameter int CNT_WIDTH  = 24,
    parameter int GATE_WIDTH = 24
) ();
    logic                  start;
    logic [3:0]            sel_i;
    logic [GATE_WIDTH-1:0] gate_cycles;
    logic [3:0]            sel_o;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;

    modport master (
        output start, sel_i, gate_cycles,
        input  sel_o, busy, done, count, overflow
    );

    modport slave (
        input  start, sel_i, gate_cycles,
        output sel_o, busy, done, count, overflow
    );
endinterface

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - ring-oscillator frequency meter: select, settle, gate-window edge count
module ro_freq_meter #(
    parameter int CNT_WIDTH     = 24,
    parameter int GATE_WIDTH    = 24,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ro_in,
    ro_freq_meter_if.slave    bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    prev_q, prev_d;
    logic                    edge_q, edge_d;
    logic [3:0]              sel_q, sel_d;
    logic [GATE_WIDTH-1:0]   gate_q, gate_d;
    logic [GATE_WIDTH-1:0]   gcnt_q, gcnt_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    overflow_q, overflow_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ro_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        edge_d     = sync_q[SYNC_STAGES-1] & ~prev_q;
        state_d    = state_q;
        sel_d      = sel_q;
        gate_d     = gate_q;
        gcnt_d     = gcnt_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_d    = bus.sel_i;
                    gate_d   = bus.gate_cycles;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    settle_d = SETTLE_LOAD;
                    busy_d   = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    if (gate_q == '0) begin
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        count_d    = cnt_q;
                        overflow_d = ovf_q;
                        state_d    = S_DONE;
                    end else begin
                        gcnt_d  = gate_q - GATE_WIDTH'(1);
                        state_d = S_MEASURE;
                    end
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            S_MEASURE: begin
                // Saturate rather than wrap so a fast oscillator reads as full-scale.
                if (edge_q) begin
                    if (cnt_q == '1) ovf_d = 1'b1;
                    else             cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (gcnt_q == '0) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    count_d    = cnt_d;
                    overflow_d = ovf_d;
                    state_d    = S_DONE;
                end else begin
                    gcnt_d = gcnt_q - GATE_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_q     <= 1'b0;
            sel_q      <= '0;
            gate_q     <= '0;
            gcnt_q     <= '0;
            settle_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            sel_q      <= sel_d;
            gate_q     <= gate_d;
            gcnt_q     <= gcnt_d;
            settle_q   <= settle_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.sel_o    = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule
